sram_rr_scheduler: RTL and testbench
====================================

# sram_rr_scheduler

Round-robin command scheduler that shares the single SRAM controller port between two write requesters (W0, W1) and two read requesters (R0, R1). Sits in the `sram_clock` domain, between the read sides of the per-requester clock-crossing FIFOs and the SRAM controller. Tracks outstanding reads so that in-order read data is steered back into the correct read-data FIFO. Throttles reads against data-FIFO fill level so returning data is never dropped.

## Interface
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 32, SRAM data width
- `MASK_W`, 4, byte write-mask width; write FIFO word is `{mask,addr,data}`, 54 bits at defaults
- `MAX_OUT`, 4, maximum reads in flight (tag FIFO depth, power of 2)

Ports:
- `sram_clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `w0_valid`, `w1_valid` in 1: the write FIFO head is valid (first-word-fall-through).
- `w0_rd_en`, `w1_rd_en` out 1: pop the write FIFO head.
- `w0_din`, `w1_din` in MASK_W+ADDR_W+DATA_W: write FIFO head.
- `r0_addr_valid`, `r1_addr_valid` in 1: the read-address FIFO head is valid.
- `r0_addr_rd_en`, `r1_addr_rd_en` out 1: pop the read-address FIFO head.
- `r0_addr`, `r1_addr` in ADDR_W: read address.
- `r0_data_prog_full`, `r1_data_prog_full` in 1: the read-data FIFO cannot absorb MAX_OUT more words.
- `sram_addr_valid` out 1: command valid.
- `sram_ready` in 1: controller accepts the command.
- `sram_addr` out ADDR_W: command address.
- `sram_data_in` out DATA_W: command write data.
- `sram_write_mask` out MASK_W: byte write mask; 0 means read.
- `sram_data_out` in DATA_W: read data, returned in issue order.
- `sram_data_out_valid` in 1: read data strobe.
- `r0_data_wr_en`, `r1_data_wr_en` out 1: push to a read-data FIFO.
- `rdata` out DATA_W: data to the read-data FIFOs. It is `sram_data_out` registered.
- `outstanding` out clog2(MAX_OUT)+1: number of reads in flight.
- `err_orphan` out 1: sticky. Set when read data arrives with no read in flight.

## Operation
- Command register: `cmd_valid`, `cmd_addr`, `cmd_data`, `cmd_mask`. It drives the `sram_*` command outputs directly.
- A slot is free when `!cmd_valid || sram_ready`.
- Eligibility:
  - Wn is eligible when `wn_valid` is high.
  - Rn is eligible when `rn_addr_valid && !rn_data_prog_full && tag FIFO not full`.
- Grant: only when a slot is free. At most one grant per cycle. Order is round-robin over W0, W1, R0, R1.
  - `last` holds the index of the last requester granted.
  - The search starts at `last+1` mod 4.
  - On reset `last` = R1, so W0 is searched first.
- On a grant:
  - Pulse the requester's `rd_en`/`addr_rd_en` in the same cycle.
  - Load the command register.
  - A read loads mask 0 and data 0.
  - A read also pushes tag (0 = R0, 1 = R1) into the tag FIFO.
- Write with mask 0: popped and discarded, with no command issued. It still counts as a grant and updates `last`. This rule exists because a zero mask would alias as a read.
- No grant while the slot is free: `cmd_valid` clears.
- Read return: when `sram_data_out_valid` is high, pop the tag and register the data into `rdata`. On the next cycle pulse `r0_data_wr_en` or `r1_data_wr_en`, selected by the tag.
- Tag FIFO empty at a return: the data is dropped and `err_orphan` is set. It clears only on reset.
- A simultaneous tag push and pop is legal. `outstanding` stays unchanged.
- `outstanding` is incremented on a read grant and decremented on a read return.

## Timing
- Reset values:
  - Command outputs: `sram_addr_valid` 0, `sram_addr`/`sram_data_in`/`sram_write_mask` 0.
  - Requester pops: all `rd_en` outputs 0.
  - Return path: both data `wr_en` outputs 0, `rdata` 0.
  - Status: `outstanding` 0, `err_orphan` 0.
  - State: tag FIFO empty, `last` = R1.
- Request latency:
  - Request valid in cycle N with the slot free → pop in N.
  - → `sram_addr_valid` in N+1.
- Sustained throughput is 1 command per cycle while `sram_ready` stays high.
- `sram_ready` low: the command and all `sram_*` outputs hold stable. There are no pops.
- Return latency: `sram_data_out_valid` in cycle M → `rN_data_wr_en` and `rdata` in M+1.
- `prog_full` is sampled at grant only. Reads already in flight are always written.
- Reset mid-operation:
  - The command is dropped and the tag FIFO is flushed.
  - The SRAM controller shares this reset, so no returns follow.

## Configuration
- `SRAM_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority W0 > W1 > R0 > R1. `last` is unused.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- `sram_sched_pkg` contains:
  - Requester index localparams `REQ_W0..REQ_R1`.
  - Widths: `ADDR_W`, `DATA_W`, `MASK_W`.
  - Write-word field offsets.
  - Tag encoding.
- One sub-module, `sram_tag_fifo`: a synchronous 1-bit FIFO of depth MAX_OUT with `count` output. It is instantiated once.

## Test plan
- **Single write:** `w0_din={4'hF,18'h00010,32'hDEADBEEF}`, `sram_ready`=1.
  - `w0_rd_en` is high for 1 cycle.
  - Next cycle: `sram_addr_valid`=1, `sram_addr`=0x10, `sram_write_mask`=0xF.
- **Round-robin:** all four requesters continuously valid, `sram_ready`=1.
  - Grant order is W0, W1, R0, R1, W0, and so on.
  - 8 commands are issued in 8 consecutive cycles.
- **Backpressure:** `sram_ready`=0 for 5 cycles with a command pending.
  - Outputs are stable and there are no pops.
  - When ready rises, the next grant occurs in the same cycle.
- **Read steering:** R0 reads at 0x5, then R1 reads at 0x6. The controller returns 0xAAAA then 0xBBBB.
  - `r0_data_wr_en` is pulsed with 0xAAAA, then `r1_data_wr_en` with 0xBBBB.
  - `outstanding` returns to 0.
- **Throttle:** MAX_OUT=4 with returns withheld. R0 continuously valid.
  - Exactly 4 reads issue and `outstanding`=4.
  - `r0_data_prog_full`=1 also blocks R0 while W0 continues to be granted.
- **Orphan and zero mask:** a return with no read in flight sets `err_orphan`=1. W1 with mask 0 is popped with no `sram_addr_valid` pulse.

Source files
------------

// File: rtl/sram_sched_pkg.sv
// ---------------------------------------------------------------------------
// sram_sched_pkg
// Shared constants for the SRAM command scheduler:
//   - default SRAM widths (address, data, byte mask) and read-tracking depth
//   - requester indices in round-robin order W0, W1, R0, R1
//   - bit offsets of the fields inside a write FIFO word {mask,addr,data}
//   - tag encoding used to steer returning read data to R0 or R1
// ---------------------------------------------------------------------------
package sram_sched_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int MAX_OUT = 4;

  localparam int WORD_W      = MASK_W + ADDR_W + DATA_W;
  localparam int WR_DATA_LSB = 0;
  localparam int WR_ADDR_LSB = DATA_W;
  localparam int WR_MASK_LSB = DATA_W + ADDR_W;

  // Reads are the upper half of the index space, so bit 1 marks a read
  localparam logic [1:0] REQ_W0 = 2'd0;
  localparam logic [1:0] REQ_W1 = 2'd1;
  localparam logic [1:0] REQ_R0 = 2'd2;
  localparam logic [1:0] REQ_R1 = 2'd3;

  localparam logic TAG_R0 = 1'b0;
  localparam logic TAG_R1 = 1'b1;

endpackage

// File: rtl/sram_tag_fifo.sv
// ---------------------------------------------------------------------------
// sram_tag_fifo
// Synchronous 1-bit FIFO recording which read requester owns each read in
// flight. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   sram_clock, reset  - clock and synchronous active-high reset
//   push_i, din_i      - enqueue one tag (ignored when full)
//   pop_i              - dequeue the head tag (ignored when empty)
//   dout_o             - head tag
//   full_o, empty_o    - occupancy flags
//   count_o            - number of stored tags
// ---------------------------------------------------------------------------
module sram_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     sram_clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     din_i,
  input  logic                     pop_i,
  output logic                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      mem_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= din_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_rr_scheduler.sv
// ---------------------------------------------------------------------------
// sram_rr_scheduler
// Shares the single SRAM controller command port between two write
// requesters (W0, W1) and two read requesters (R0, R1). A one-entry command
// register drives the controller; returning in-order read data is steered
// to the owning read-data FIFO using a tag FIFO of reads in flight.
//
// Build option: define SRAM_SCHED_FIXED_PRIO_EN for fixed priority
// W0 > W1 > R0 > R1; otherwise arbitration is round-robin.
//
// Ports:
//   sram_clock, reset              - clock, synchronous active-high reset
//   wN_valid / wN_rd_en / wN_din   - write FIFO head {mask,addr,data} and pop
//   rN_addr_valid / rN_addr_rd_en
//   / rN_addr                      - read-address FIFO head and pop
//   rN_data_prog_full              - read-data FIFO cannot take MAX_OUT more
//   sram_addr_valid, sram_ready,
//   sram_addr, sram_data_in,
//   sram_write_mask                - command to controller (mask 0 = read)
//   sram_data_out(_valid)          - in-order read data from controller
//   rN_data_wr_en, rdata           - push returning data to read-data FIFOs
//   outstanding                    - reads in flight
//   err_orphan                     - sticky: data returned with none in flight
// ---------------------------------------------------------------------------
module sram_rr_scheduler
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W  = sram_sched_pkg::ADDR_W,
  parameter int DATA_W  = sram_sched_pkg::DATA_W,
  parameter int MASK_W  = sram_sched_pkg::MASK_W,
  parameter int MAX_OUT = sram_sched_pkg::MAX_OUT
) (
  input  logic                              sram_clock,
  input  logic                              reset,
  input  logic                              w0_valid,
  input  logic                              w1_valid,
  output logic                              w0_rd_en,
  output logic                              w1_rd_en,
  input  logic [MASK_W+ADDR_W+DATA_W-1:0]   w0_din,
  input  logic [MASK_W+ADDR_W+DATA_W-1:0]   w1_din,
  input  logic                              r0_addr_valid,
  input  logic                              r1_addr_valid,
  output logic                              r0_addr_rd_en,
  output logic                              r1_addr_rd_en,
  input  logic [ADDR_W-1:0]                 r0_addr,
  input  logic [ADDR_W-1:0]                 r1_addr,
  input  logic                              r0_data_prog_full,
  input  logic                              r1_data_prog_full,
  output logic                              sram_addr_valid,
  input  logic                              sram_ready,
  output logic [ADDR_W-1:0]                 sram_addr,
  output logic [DATA_W-1:0]                 sram_data_in,
  output logic [MASK_W-1:0]                 sram_write_mask,
  input  logic [DATA_W-1:0]                 sram_data_out,
  input  logic                              sram_data_out_valid,
  output logic                              r0_data_wr_en,
  output logic                              r1_data_wr_en,
  output logic [DATA_W-1:0]                 rdata,
  output logic [$clog2(MAX_OUT):0]          outstanding,
  output logic                              err_orphan
);

  localparam int CNT_W    = $clog2(MAX_OUT) + 1;
  localparam int ADDR_LSB = DATA_W;
  localparam int MASK_LSB = DATA_W + ADDR_W;

  logic                           cmdValid_q, cmdValid_d;
  logic [ADDR_W-1:0]              cmdAddr_q, cmdAddr_d;
  logic [DATA_W-1:0]              cmdData_q, cmdData_d;
  logic [MASK_W-1:0]              cmdMask_q, cmdMask_d;
  logic [1:0]                     last_q, last_d;
  logic                           r0Wr_q, r1Wr_q;
  logic [DATA_W-1:0]              rdata_q;
  logic                           orphan_q;

  logic                           slotFree;
  logic [3:0]                     elig;
  logic                           grantValid;
  logic [1:0]                     grantIdx;
  logic                           grantIsRead;
  logic [MASK_W+ADDR_W+DATA_W-1:0] wordSel;
  logic [MASK_W-1:0]              wordMask;
  logic                           tagPush, tagPushVal, tagPop, tagHead;
  logic                           tagFull, tagEmpty;
  logic [CNT_W-1:0]               tagCount;

  assign slotFree = !cmdValid_q || sram_ready;

  // Reads are throttled so every read in flight is guaranteed a FIFO slot
  assign elig[REQ_W0] = w0_valid;
  assign elig[REQ_W1] = w1_valid;
  assign elig[REQ_R0] = r0_addr_valid && !r0_data_prog_full && !tagFull;
  assign elig[REQ_R1] = r1_addr_valid && !r1_data_prog_full && !tagFull;

  // Arbitration; loops run backwards so the highest-priority candidate is
  // the last one assigned. Reset suppresses all pops.
  always_comb begin
    logic [1:0] idx;
    grantValid = 1'b0;
    grantIdx   = REQ_W0;
    idx        = '0;
    if (!reset && slotFree) begin
`ifdef SRAM_SCHED_FIXED_PRIO_EN
      for (int k = 3; k >= 0; k--) begin
        idx = 2'(k);
        if (elig[idx]) begin
          grantValid = 1'b1;
          grantIdx   = idx;
        end
      end
`else
      for (int k = 4; k >= 1; k--) begin
        idx = last_q + 2'(k);
        if (elig[idx]) begin
          grantValid = 1'b1;
          grantIdx   = idx;
        end
      end
`endif
    end
  end

  assign grantIsRead   = grantIdx[1];
  assign w0_rd_en      = grantValid && (grantIdx == REQ_W0);
  assign w1_rd_en      = grantValid && (grantIdx == REQ_W1);
  assign r0_addr_rd_en = grantValid && (grantIdx == REQ_R0);
  assign r1_addr_rd_en = grantValid && (grantIdx == REQ_R1);

  assign wordSel  = (grantIdx == REQ_W1) ? w1_din : w0_din;
  assign wordMask = wordSel[MASK_LSB +: MASK_W];

  // Command register load. A zero-mask write would look like a read to the
  // controller, so it is consumed without issuing anything.
  always_comb begin
    cmdValid_d = cmdValid_q;
    cmdAddr_d  = cmdAddr_q;
    cmdData_d  = cmdData_q;
    cmdMask_d  = cmdMask_q;
    last_d     = grantValid ? grantIdx : last_q;
    if (slotFree) begin
      if (grantValid && grantIsRead) begin
        cmdValid_d = 1'b1;
        cmdAddr_d  = (grantIdx == REQ_R1) ? r1_addr : r0_addr;
        cmdData_d  = '0;
        cmdMask_d  = '0;
      end else if (grantValid && (wordMask != '0)) begin
        cmdValid_d = 1'b1;
        cmdAddr_d  = wordSel[ADDR_LSB +: ADDR_W];
        cmdData_d  = wordSel[DATA_W-1:0];
        cmdMask_d  = wordMask;
      end else begin
        cmdValid_d = 1'b0;
      end
    end
  end

  assign tagPush    = grantValid && grantIsRead;
  assign tagPushVal = (grantIdx == REQ_R1) ? TAG_R1 : TAG_R0;
  assign tagPop     = sram_data_out_valid && !tagEmpty;

  sram_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tagFifo (
    .sram_clock (sram_clock),
    .reset      (reset),
    .push_i     (tagPush),
    .din_i      (tagPushVal),
    .pop_i      (tagPop),
    .dout_o     (tagHead),
    .full_o     (tagFull),
    .empty_o    (tagEmpty),
    .count_o    (tagCount)
  );

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      cmdValid_q <= 1'b0;
      cmdAddr_q  <= '0;
      cmdData_q  <= '0;
      cmdMask_q  <= '0;
      last_q     <= REQ_R1;
      r0Wr_q     <= 1'b0;
      r1Wr_q     <= 1'b0;
      rdata_q    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      cmdValid_q <= cmdValid_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdData_q  <= cmdData_d;
      cmdMask_q  <= cmdMask_d;
      last_q     <= last_d;
      r0Wr_q     <= tagPop && (tagHead == TAG_R0);
      r1Wr_q     <= tagPop && (tagHead == TAG_R1);
      if (tagPop) begin
        rdata_q <= sram_data_out;
      end
      if (sram_data_out_valid && tagEmpty) begin
        orphan_q <= 1'b1;
      end
    end
  end

  assign sram_addr_valid = cmdValid_q;
  assign sram_addr       = cmdAddr_q;
  assign sram_data_in    = cmdData_q;
  assign sram_write_mask = cmdMask_q;
  assign r0_data_wr_en   = r0Wr_q;
  assign r1_data_wr_en   = r1Wr_q;
  assign rdata           = rdata_q;
  assign outstanding     = tagCount;
  assign err_orphan      = orphan_q;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sram_rr_scheduler
// Self-checking bench for sram_rr_scheduler (default round-robin build).
// A behavioural model built from queues tracks the expected command, the
// reads in flight and the return path every cycle; directed sequences and a
// vector table add hand-derived expectations on top.
// ---------------------------------------------------------------------------
module tb_sram_rr_scheduler;

  localparam int MAX_OUT = 4;

  logic        sram_clock = 1'b0;
  logic        reset;
  logic        w0_valid, w1_valid, w0_rd_en, w1_rd_en;
  logic [53:0] w0_din, w1_din;
  logic        r0_addr_valid, r1_addr_valid, r0_addr_rd_en, r1_addr_rd_en;
  logic [17:0] r0_addr, r1_addr;
  logic        r0_data_prog_full, r1_data_prog_full;
  logic        sram_addr_valid, sram_ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_data_in;
  logic [3:0]  sram_write_mask;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic        r0_data_wr_en, r1_data_wr_en;
  logic [31:0] rdata;
  logic [2:0]  outstanding;
  logic        err_orphan;

  int compared   = 0;
  int mismatched = 0;

  sram_rr_scheduler dut (
    .sram_clock          (sram_clock),
    .reset               (reset),
    .w0_valid            (w0_valid),
    .w1_valid            (w1_valid),
    .w0_rd_en            (w0_rd_en),
    .w1_rd_en            (w1_rd_en),
    .w0_din              (w0_din),
    .w1_din              (w1_din),
    .r0_addr_valid       (r0_addr_valid),
    .r1_addr_valid       (r1_addr_valid),
    .r0_addr_rd_en       (r0_addr_rd_en),
    .r1_addr_rd_en       (r1_addr_rd_en),
    .r0_addr             (r0_addr),
    .r1_addr             (r1_addr),
    .r0_data_prog_full   (r0_data_prog_full),
    .r1_data_prog_full   (r1_data_prog_full),
    .sram_addr_valid     (sram_addr_valid),
    .sram_ready          (sram_ready),
    .sram_addr           (sram_addr),
    .sram_data_in        (sram_data_in),
    .sram_write_mask     (sram_write_mask),
    .sram_data_out       (sram_data_out),
    .sram_data_out_valid (sram_data_out_valid),
    .r0_data_wr_en       (r0_data_wr_en),
    .r1_data_wr_en       (r1_data_wr_en),
    .rdata               (rdata),
    .outstanding         (outstanding),
    .err_orphan          (err_orphan)
  );

  always #5 sram_clock = ~sram_clock;

  // Behavioural model state
  bit          mCmdValid;
  logic [17:0] mAddr;
  logic [31:0] mData;
  logic [3:0]  mMask;
  int          mLast;
  bit          mTags[$];
  bit          mWr0, mWr1, mOrphan;
  logic [31:0] mRdata;
  int          mGrant;

  typedef struct {
    logic [3:0] valids;
    logic [1:0] pf;
    logic [3:0] expPops;
    logic       expCmd;
  } vec_t;

  vec_t tbl[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [1:0] pf, input logic rdy,
                               input logic dv, input logic [31:0] dout);
    w0_valid            = v[3];
    w1_valid            = v[2];
    r0_addr_valid       = v[1];
    r1_addr_valid       = v[0];
    r0_data_prog_full   = pf[1];
    r1_data_prog_full   = pf[0];
    sram_ready          = rdy;
    sram_data_out_valid = dv;
    sram_data_out       = dout;
  endtask

  task automatic resetModel();
    mCmdValid = 0; mAddr = '0; mData = '0; mMask = '0;
    mLast = 3; mTags.delete();
    mWr0 = 0; mWr1 = 0; mOrphan = 0; mRdata = '0;
  endtask

  // Expected grant from the current inputs, then compare every output
  task automatic sample();
    bit elig[4];
    #1;
    mGrant = -1;
    elig[0] = w0_valid;
    elig[1] = w1_valid;
    elig[2] = r0_addr_valid && !r0_data_prog_full && (mTags.size() < MAX_OUT);
    elig[3] = r1_addr_valid && !r1_data_prog_full && (mTags.size() < MAX_OUT);
    if (!reset && (!mCmdValid || sram_ready)) begin
      for (int k = 1; k <= 4; k++) begin
        if (mGrant < 0 && elig[(mLast + k) % 4]) mGrant = (mLast + k) % 4;
      end
    end
    checkOutput("pops", 64'({w0_rd_en, w1_rd_en, r0_addr_rd_en, r1_addr_rd_en}),
                64'({mGrant == 0, mGrant == 1, mGrant == 2, mGrant == 3}));
    checkOutput("cmd", 64'({sram_addr_valid, sram_addr, sram_data_in, sram_write_mask}),
                64'({mCmdValid, mAddr, mData, mMask}));
    checkOutput("ret", 64'({r0_data_wr_en, r1_data_wr_en, rdata}), 64'({mWr0, mWr1, mRdata}));
    checkOutput("status", 64'({outstanding, err_orphan}), 64'({3'(mTags.size()), mOrphan}));
  endtask

  // Clock edge, then advance the model with the inputs that were sampled
  task automatic advance();
    logic [53:0] w;
    @(posedge sram_clock);
    if (reset) begin
      resetModel();
    end else begin
      mWr0 = 0; mWr1 = 0;
      if (sram_data_out_valid) begin
        if (mTags.size() > 0) begin
          bit t;
          t = mTags.pop_front();
          mWr0 = (t == 0); mWr1 = (t == 1); mRdata = sram_data_out;
        end else begin
          mOrphan = 1;
        end
      end
      if (!mCmdValid || sram_ready) begin
        if (mGrant == 0 || mGrant == 1) begin
          w = (mGrant == 0) ? w0_din : w1_din;
          if (w[53:50] != 0) begin
            mCmdValid = 1; mMask = w[53:50]; mAddr = w[49:32]; mData = w[31:0];
          end else begin
            mCmdValid = 0;
          end
        end else if (mGrant >= 2) begin
          mCmdValid = 1; mMask = 0; mData = 0;
          mAddr = (mGrant == 2) ? r0_addr : r1_addr;
          mTags.push_back(mGrant == 3);
        end else begin
          mCmdValid = 0;
        end
      end
      if (mGrant >= 0) mLast = mGrant;
    end
    @(negedge sram_clock);
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    sample();
    advance();
    reset = 1'b0;
  endtask

  initial begin
    int pops;
    logic [3:0] m;
    w0_din = '0; w1_din = '0; r0_addr = '0; r1_addr = '0;
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge sram_clock);
    @(negedge sram_clock);
    resetModel();
    reset = 1'b0;

    // Reset state
    sample();
    checkOutput("resetState", 64'({w0_rd_en, w1_rd_en, r0_addr_rd_en, r1_addr_rd_en, sram_addr_valid,
                sram_addr, sram_data_in, sram_write_mask, r0_data_wr_en, r1_data_wr_en,
                outstanding, err_orphan}), 64'h0);
    checkOutput("resetRdata", 64'(rdata), 64'h0);
    advance();

    // Single write
    w0_din = {4'hF, 18'h00010, 32'hDEADBEEF};
    applyStimulus(4'b1000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("singleWritePop", 64'(w0_rd_en), 64'h1);
    advance();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("singleWriteCmd", 64'({sram_addr_valid, sram_addr, sram_write_mask, w0_rd_en}),
                64'({1'b1, 18'h10, 4'hF, 1'b0}));
    advance();

    // Round-robin vector table from reset
    tbl[0]  = '{4'b1111, 2'b00, 4'b1000, 1'b0};
    tbl[1]  = '{4'b1111, 2'b00, 4'b0100, 1'b1};
    tbl[2]  = '{4'b1111, 2'b00, 4'b0010, 1'b1};
    tbl[3]  = '{4'b1111, 2'b00, 4'b0001, 1'b1};
    tbl[4]  = '{4'b1111, 2'b00, 4'b1000, 1'b1};
    tbl[5]  = '{4'b1111, 2'b00, 4'b0100, 1'b1};
    tbl[6]  = '{4'b1111, 2'b00, 4'b0010, 1'b1};
    tbl[7]  = '{4'b1111, 2'b00, 4'b0001, 1'b1};
    tbl[8]  = '{4'b0010, 2'b00, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0100, 2'b00, 4'b0100, 1'b0};
    tbl[10] = '{4'b1010, 2'b10, 4'b1000, 1'b1};
    doReset();
    w0_din = {4'hF, 18'h100, 32'h11111111};
    w1_din = {4'hF, 18'h101, 32'h22222222};
    r0_addr = 18'h200; r1_addr = 18'h201;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].valids, tbl[i].pf, 1'b1, 1'b0, 32'h0);
      sample();
      checkOutput($sformatf("tblPops%0d", i),
                  64'({w0_rd_en, w1_rd_en, r0_addr_rd_en, r1_addr_rd_en}), 64'(tbl[i].expPops));
      checkOutput($sformatf("tblCmd%0d", i), 64'(sram_addr_valid), 64'(tbl[i].expCmd));
      advance();
    end
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("tblOutstanding", 64'(outstanding), 64'd4);
    advance();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 2'b00, 1'b1, 1'b1, $urandom);
      sample();
      advance();
    end

    // Backpressure
    doReset();
    applyStimulus(4'b1000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    advance();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, 2'b00, 1'b0, 1'b0, 32'h0);
      sample();
      checkOutput("bpHold", 64'({sram_addr_valid, sram_addr, w1_rd_en, w0_rd_en}),
                  64'({1'b1, 18'h100, 1'b0, 1'b0}));
      advance();
    end
    applyStimulus(4'b0100, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("bpRelease", 64'(w1_rd_en), 64'h1);
    advance();

    // Read steering
    doReset();
    r0_addr = 18'h5; r1_addr = 18'h6;
    applyStimulus(4'b0010, 2'b00, 1'b1, 1'b0, 32'h0); sample(); advance();
    applyStimulus(4'b0001, 2'b00, 1'b1, 1'b0, 32'h0); sample(); advance();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b1, 32'hAAAA); sample(); advance();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b1, 32'hBBBB);
    sample();
    checkOutput("steerR0", 64'({r0_data_wr_en, r1_data_wr_en, rdata}), 64'({1'b1, 1'b0, 32'hAAAA}));
    advance();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("steerR1", 64'({r0_data_wr_en, r1_data_wr_en, rdata}), 64'({1'b0, 1'b1, 32'hBBBB}));
    checkOutput("steerOutstanding", 64'(outstanding), 64'd0);
    advance();

    // Throttle against tag FIFO depth
    doReset();
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0010, 2'b00, 1'b1, 1'b0, 32'h0);
      sample();
      pops += int'(r0_addr_rd_en);
      advance();
    end
    checkOutput("throttlePops", 64'(pops), 64'd4);
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("throttleOutstanding", 64'(outstanding), 64'd4);
    advance();

    // prog_full blocks R0 while W0 keeps being granted
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b1010, 2'b10, 1'b1, 1'b0, 32'h0);
      sample();
      checkOutput("progFull", 64'({w0_rd_en, r0_addr_rd_en}), 64'({1'b1, 1'b0}));
      advance();
    end

    // Orphan return and zero-mask write
    doReset();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b1, 32'h1234); sample(); advance();
    w1_din = {4'h0, 18'h3F, 32'h55};
    applyStimulus(4'b0100, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("orphan", 64'({err_orphan, r0_data_wr_en, r1_data_wr_en}), 64'({1'b1, 1'b0, 1'b0}));
    checkOutput("zeroMaskPop", 64'(w1_rd_en), 64'h1);
    advance();
    applyStimulus(4'b0000, 2'b00, 1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("zeroMaskNoCmd", 64'({sram_addr_valid, err_orphan}), 64'({1'b0, 1'b1}));
    advance();

    // Randomized traffic against the model, with one mid-run reset
    doReset();
    for (int i = 0; i < 3000; i++) begin
      m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      w0_din = {m, 18'($urandom), 32'($urandom)};
      m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      w1_din = {m, 18'($urandom), 32'($urandom)};
      r0_addr = 18'($urandom);
      r1_addr = 18'($urandom);
      reset = (i == 1500);
      applyStimulus(4'($urandom), {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
                    $urandom_range(0, 3) != 0,
                    !reset && (mTags.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
      sample();
      advance();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
